dram_responder: RTL

// Memory-side responder for the CPU memory controller: receives we/dram_addr/dram_data
// and returns dram_dq from an on-chip block-RAM array. It samples on posedge clock; the

---
 rtl/dram_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dram_responder.sv
// ---------------------------------------------------------------------------
// dram_responder
//
// Memory-side responder for the CPU memory controller. It services word
// writes and pipelined word reads from an on-chip block-RAM array. After
// reset the array is zero-filled one word per clock (unless CLEAR_ON_RESET
// is 0), and only then does the responder raise ready and honour accesses.
//
// Ports:
//   clock_i          system clock, all state updates on posedge
//   reset_i          asynchronous, active-high reset
//   we_i             write enable from the controller
//   dram_addr_i      word address from the controller (high bits alias)
//   dram_data_i      write data from the controller
//   dram_dq_o        registered read data to the controller
//   dq_valid_o       dram_dq_o holds data for a sampled address
//   ready_o          clear sequence finished, accesses are honoured
//   dropped_write_o  sticky flag: a write arrived while ready_o was low
// ---------------------------------------------------------------------------
module dram_responder #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH_LOG2     = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] dram_addr_i,
    input  logic [DATA_WIDTH-1:0] dram_data_i,
    output logic [DATA_WIDTH-1:0] dram_dq_o,
    output logic                  dq_valid_o,
    output logic                  ready_o,
    output logic                  dropped_write_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   clrCnt_q, clrCnt_d;
    logic                    ready_q, ready_d;
    logic                    dropped_q, dropped_d;

    logic                    memWe;
    logic [DEPTH_LOG2-1:0]   memWaddr;
    logic [DATA_WIDTH-1:0]   memWdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   idx;

    logic [DATA_WIDTH-1:0]   pipeData_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipeValid_q;

    // Only the low address bits select a word; the rest alias.
    assign idx = dram_addr_i[DEPTH_LOG2-1:0];

    generate
        if (DEPTH_LOG2 < ADDR_WIDTH) begin : gHighAddr
            logic unusedHighAddr;
            assign unusedHighAddr = ^dram_addr_i[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    // Next-state logic. The single memory write port is shared: the clear
    // sequence owns it while in CLEAR, the controller owns it once ready.
    // In RUN, ready_q is checked too because with CLEAR_ON_RESET=0 the first
    // edge after reset must still ignore the controller.
    always_comb begin
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        ready_d   = ready_q;
        dropped_d = dropped_q;
        memWe     = 1'b0;
        memWaddr  = idx;
        memWdata  = dram_data_i;

        case (state_q)
            ST_CLEAR: begin
                memWe    = 1'b1;
                memWaddr = clrCnt_q;
                memWdata = '0;
                clrCnt_d = clrCnt_q + DEPTH_LOG2'(1);
                if (clrCnt_q == {DEPTH_LOG2{1'b1}}) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
                if (ready_q && we_i) begin
                    memWe = 1'b1;
                end
            end
        endcase

        if (!ready_q && we_i) begin
            dropped_d = 1'b1;
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= RESET_STATE;
            clrCnt_q  <= '0;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clrCnt_q  <= clrCnt_d;
            ready_q   <= ready_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage array. Deliberately has no reset so it maps onto block RAM;
    // only the CLEAR sequence zeroes it.
    always_ff @(posedge clock_i) begin
        if (memWe) begin
            mem[memWaddr] <= memWdata;
        end
    end

    // Read pipeline. Stage 0 captures mem[idx] on the same edge as any write,
    // so a same-edge read sees the old word (read-first). Further stages just
    // delay data and valid; once valid enters it never leaves until reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipeData_q[i] <= '0;
            end
            pipeValid_q <= '0;
        end else begin
            if (ready_q) begin
                pipeData_q[0]  <= mem[idx];
                pipeValid_q[0] <= 1'b1;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeData_q[i]  <= pipeData_q[i-1];
                pipeValid_q[i] <= pipeValid_q[i-1];
            end
        end
    end

    assign dram_dq_o       = pipeData_q[READ_LATENCY-1];
    assign dq_valid_o      = pipeValid_q[READ_LATENCY-1];
    assign ready_o         = ready_q;
    assign dropped_write_o = dropped_q;

endmodule
